// File: rtl/dcm_freq_decoder.sv
// Measures the clk_2 period in clk_1 edges and decodes it to one of eight divider codes.
// Tracks lock against repeated identical codes and flags stopped clk_2 or a code mismatch.
module dcm_freq_decoder #(
   parameter int SYNC_STAGES   = 2,
   parameter int CONFIRM       = 2,
   parameter int TIMEOUT_TICKS = 255
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       clk_1,
   input  logic       clk_2,
   input  logic [2:0] expected,
   output logic [2:0] prog_meas,
   output logic [7:0] period_cnt,
   output logic       meas_valid,
   output logic       meas_err,
   output logic       locked,
   output logic       mismatch,
   output logic       timeout
);

   localparam logic [2:0] CONFIRM_L = 3'(CONFIRM);
   localparam logic [7:0] TIMEOUT_L = 8'(TIMEOUT_TICKS);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      MEASURE = 2'd1,
      EVAL    = 2'd2
   } state_t;

   function automatic logic is_pow2(input logic [7:0] v);
      is_pow2 = (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
   endfunction

   function automatic logic [2:0] log2_8(input logic [7:0] v);
      log2_8 = 3'd0;
      for (int i = 0; i < 8; i++) begin
         if (v[i]) begin
            log2_8 = 3'(i);
         end
      end
   endfunction

   state_t                 state_r;
   logic [SYNC_STAGES-1:0] sync1_r;
   logic [SYNC_STAGES-1:0] sync2_r;
   logic                   prev1_r;
   logic                   prev2_r;
   logic [7:0]             cnt_r;
   logic [2:0]             conf_r;

   logic       rise1_s;
   logic       rise2_s;
   logic [7:0] cnt_inc_s;
   logic [7:0] cap_s;
   logic       cap_pow2_s;
   logic [2:0] cap_code_s;
   logic [2:0] conf_inc_s;
   logic [2:0] conf_next_s;

   // Synchronizers and previous-value flops for rise detection
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_r <= '0;
         sync2_r <= '0;
         prev1_r <= 1'b0;
         prev2_r <= 1'b0;
      end else begin
         sync1_r <= {sync1_r[SYNC_STAGES-2:0], clk_1};
         sync2_r <= {sync2_r[SYNC_STAGES-2:0], clk_2};
         prev1_r <= sync1_r[SYNC_STAGES-1];
         prev2_r <= sync2_r[SYNC_STAGES-1];
      end
   end

   // Edge detect, closing-period capture (a coincident clk_1 rise counts) and confirm update
   always_comb begin
      rise1_s    = sync1_r[SYNC_STAGES-1] & ~prev1_r;
      rise2_s    = sync2_r[SYNC_STAGES-1] & ~prev2_r;
      cnt_inc_s  = (cnt_r == 8'hFF) ? 8'hFF : (cnt_r + 8'd1);
      if (rise1_s) begin
         cap_s = cnt_inc_s;
      end else begin
         cap_s = cnt_r;
      end
      cap_pow2_s = is_pow2(cap_s);
      cap_code_s = log2_8(cap_s);
      conf_inc_s = (conf_r == 3'd7) ? 3'd7 : (conf_r + 3'd1);
      if ((conf_r != 3'd0) && (cap_code_s == prog_meas)) begin
         conf_next_s = conf_inc_s;
      end else begin
         conf_next_s = 3'd1;
      end
   end

   // Measurement FSM with registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= IDLE;
         cnt_r      <= 8'd0;
         conf_r     <= 3'd0;
         prog_meas  <= 3'd0;
         period_cnt <= 8'd0;
         meas_valid <= 1'b0;
         meas_err   <= 1'b0;
         locked     <= 1'b0;
         mismatch   <= 1'b0;
         timeout    <= 1'b0;
      end else begin
         meas_valid <= 1'b0;
         meas_err   <= 1'b0;
         mismatch   <= locked & (prog_meas != expected);
         case (state_r)
            IDLE: begin
               cnt_r <= 8'd0;
               if (rise2_s) begin
                  state_r <= MEASURE;
                  timeout <= 1'b0;
               end
            end
            MEASURE: begin
               if (rise2_s) begin
                  state_r    <= EVAL;
                  cnt_r      <= 8'd0;
                  period_cnt <= cap_s;
                  if (cap_pow2_s) begin
                     prog_meas  <= cap_code_s;
                     meas_valid <= 1'b1;
                     conf_r     <= conf_next_s;
                     locked     <= (conf_next_s >= CONFIRM_L);
                  end else begin
                     meas_err <= 1'b1;
                     conf_r   <= 3'd0;
                     locked   <= 1'b0;
                  end
               end else if (rise1_s) begin
                  if (cnt_inc_s >= TIMEOUT_L) begin
                     state_r <= IDLE;
                     cnt_r   <= 8'd0;
                     timeout <= 1'b1;
                     locked  <= 1'b0;
                     conf_r  <= 3'd0;
                  end else begin
                     cnt_r <= cnt_inc_s;
                  end
               end
            end
            EVAL: begin
               // clk_2 rises here are illegal and deliberately ignored
               state_r <= MEASURE;
               cnt_r   <= rise1_s ? 8'd1 : 8'd0;
            end
            default: begin
               state_r <= IDLE;
               cnt_r   <= 8'd0;
            end
         endcase
      end
   end

endmodule
